shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the number of serial bits per word (range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means the first received bit lands in data_out[DATA_W-1] and 0 means it lands in data_out[0].
REQ-003 SHALL have port clk_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: word request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of the word in progress.
REQ-007 SHALL have port data_en, input, 1 bit: qualifies serial_data for the current cycle.
REQ-008 SHALL have port serial_data, input, 1 bit: serial bit, ignored (may be X) when data_en=0.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed word.
REQ-011 SHALL have port data_out, output, DATA_W bits: last completed word, held between completions.
REQ-012 SHALL have port bit_cnt, output, $clog2(DATA_W+1) bits: number of bits accepted in the current word.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE, plus PARITY when the macro in REQ-026 is defined.
REQ-014 In IDLE with start=1 at edge k, SHALL clear the shifter and bit_cnt and enter SHIFT at edge k; no bit is sampled at edge k.
REQ-015 In SHIFT, SHALL shift serial_data in and increment bit_cnt on every edge with data_en=1; edges with data_en=0 SHALL leave shifter and bit_cnt unchanged (stall, no timeout).
REQ-016 On the edge accepting bit DATA_W, SHALL load data_out with the full word and enter DONE (or PARITY); with continuous data_en, done is high in the cycle following edge k+DATA_W.
REQ-017 In DONE, SHALL assert done for exactly one cycle, then return to IDLE unconditionally; start in DONE is ignored, and a new word needs start in IDLE.
REQ-018 start while busy=1 SHALL be ignored with no effect on the word in progress.
REQ-019 abort=1 in SHIFT or PARITY SHALL return to IDLE at the next edge, discard partial bits, leave data_out unchanged and produce no done; abort has priority over data_en on the same edge.
REQ-020 abort in IDLE or DONE SHALL have no effect; in DONE the done pulse still occurs.
REQ-021 bit_cnt SHALL read 0 in IDLE and saturate at DATA_W until the next start.

Reset
REQ-022 reset=1 SHALL immediately force the state to IDLE, with busy=0, done=0, data_out=0, bit_cnt=0 and the shifter cleared, independent of clk_50.
REQ-023 Reset asserted mid-word SHALL discard the word; after release, the block SHALL wait in IDLE for a fresh start.
REQ-024 Deassertion of reset SHALL be the only path out of reset, and the first start is accepted at the first rising edge after release.

Configuration
REQ-025 Without the macro, the word SHALL be exactly DATA_W bits and no parity port SHALL exist.
REQ-026 With SHIFT_PARITY_CHK_EN defined, the block SHALL add the output port parity_err (1 bit) and, after bit DATA_W, enter PARITY to accept one more data_en-qualified bit as even parity over the word; data_out SHALL load at the parity edge, and parity_err SHALL be valid with done and held until the next done or reset.

Structure
REQ-027 The shared package shift_seq_pkg SHALL hold the state enum typedef (state_t), the default DATA_W constant, and the count-width function.
REQ-028 The shifter SHALL be the separate sub-module shift_reg_sipo (ports clk_50, reset, clr, shift_en, serial_in, par_out; parameters DATA_W and MSB_FIRST), and shift_seq_ctrl SHALL hold only the FSM, counter and output registers.

Verification
REQ-029 The bench SHALL cover: start, then 8 continuous bits 1,0,1,0,0,1,0,1 with MSB_FIRST=1 -> done at cycle 9 after start, data_out=0xA5, bit_cnt=8.
REQ-030 The bench SHALL cover: the same bits with 3 data_en=0 gaps inserted -> done at cycle 12, data_out=0xA5, serial_data=X during the gaps has no effect.
REQ-031 The bench SHALL cover: abort after 4 bits with data_out previously 0xA5 -> IDLE next cycle, no done, data_out=0xA5, bit_cnt=0.
REQ-032 The bench SHALL cover: reset pulse asynchronous to clk_50 mid-word -> busy=0 and data_out=0 immediately, then a new word 0x3C completes normally.
REQ-033 The bench SHALL cover: start held high through the whole word and DONE -> exactly one word accepted and done pulses once; re-acceptance happens only in IDLE.
REQ-034 The bench SHALL cover, with SHIFT_PARITY_CHK_EN defined: word 0xA5 followed by parity bit 1 -> parity_err=1, and by parity bit 0 -> parity_err=0, with done at cycle 10.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the serial-to-parallel word sequencer.
// SHIFT_PARITY_CHK_EN adds the PARITY state used by the optional parity check.
package shift_seq_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2
`ifdef SHIFT_PARITY_CHK_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

  // Width needed to hold a bit count of 0..dw inclusive.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/shift_reg_sipo.sv
// Serial-in parallel-out shifter; MSB_FIRST selects the end the first bit ends up at.
module shift_reg_sipo #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] par_out
);

  logic [DATA_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) sh_d = {sh_q[DATA_W-2:0], serial_in};
      else                sh_d = {serial_in, sh_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign par_out = sh_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Word sequencer: FSM, bit counter and output registers around shift_reg_sipo.
// Define SHIFT_PARITY_CHK_EN to add a trailing even-parity bit and the parity_err port.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     data_en,
  input  logic                     serial_data,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        data_out,
  output logic [cnt_w(DATA_W)-1:0] bit_cnt
`ifdef SHIFT_PARITY_CHK_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int            CW   = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              clr, shift_en;
  logic [DATA_W-1:0] par_out;

  shift_reg_sipo #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_sipo (
    .clk_50   (clk_50),
    .reset    (reset),
    .clr      (clr),
    .shift_en (shift_en),
    .serial_in(serial_data),
    .par_out  (par_out)
  );

`ifdef SHIFT_PARITY_CHK_EN
  logic perr_q, perr_d;
`else
  // The shifter only updates on the last-bit edge, so the word loaded into
  // data_out at that same edge is formed here from the incoming bit.
  logic [DATA_W-1:0] word_nxt;
  if (MSB_FIRST != 0) begin : g_msb
    assign word_nxt = {par_out[DATA_W-2:0], serial_data};
  end else begin : g_lsb
    assign word_nxt = {serial_data, par_out[DATA_W-1:1]};
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    clr      = 1'b0;
    shift_en = 1'b0;
`ifdef SHIFT_PARITY_CHK_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (data_en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SHIFT_PARITY_CHK_EN
            state_d = PARITY;
`else
            dout_d  = word_nxt;
            state_d = DONE;
`endif
          end
        end
      end
`ifdef SHIFT_PARITY_CHK_EN
      PARITY: begin
        if (abort) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (data_en) begin
          // Even parity: word plus parity bit must carry an even number of ones.
          dout_d  = par_out;
          perr_d  = (^par_out) ^ serial_data;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef SHIFT_PARITY_CHK_EN
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign data_out = dout_q;
  assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized scoreboard bench for shift_seq_ctrl: driver queues expected words,
// a negedge monitor checks every done pulse against them.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int DW   = 8;
  localparam int CW   = cnt_w(DW);
  localparam bit MSBF = 1'b1;
`ifdef SHIFT_PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk_50 = 1'b0;
  logic          reset, start, abort, data_en, serial_data;
  logic          busy, done;
  logic [DW-1:0] data_out;
  logic [CW-1:0] bit_cnt;
`ifdef SHIFT_PARITY_CHK_EN
  logic          parity_err;
`endif

  shift_seq_ctrl #(.DATA_W(DW), .MSB_FIRST(1)) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .data_en    (data_en),
    .serial_data(serial_data),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .bit_cnt    (bit_cnt)
`ifdef SHIFT_PARITY_CHK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  typedef struct {
    logic [DW-1:0] word;
    int            k;
    int            lat;
    bit            perr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding word.
  always @(negedge clk_50) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("data_out_at_done", data_out, mon_e.word);
        chk("bit_cnt_at_done", bit_cnt, DW);
        chk("done_latency", cyc - mon_e.k, mon_e.lat);
`ifdef SHIFT_PARITY_CHK_EN
        chk("parity_err", parity_err, mon_e.perr);
`endif
      end
    end
  end

  // bseq[i] is the i-th bit sent on the wire; gmask adds one stall before bit i.
  task automatic send(input logic [DW-1:0] bseq, input logic [DW:0] gmask,
                      input int maxgap, input bit hold, input bit pbit);
    int            g[DW+1];
    int            lat;
    logic [DW-1:0] w;
    exp_t          e;
    lat = 0;
    w   = '0;
    for (int i = 0; i <= DW; i++) begin
      g[i] = int'(gmask[i]) + int'($urandom_range(0, maxgap));
      if (i < DW || PAR) lat += g[i] + 1;
    end
    for (int i = 0; i < DW; i++) begin
      if (MSBF) w = w + (DW'(bseq[i]) << (DW - 1 - i));
      else      w = w + (DW'(bseq[i]) << i);
    end
    start = 1'b1;
    tick();
    e.k    = cyc;
    e.word = w;
    e.lat  = lat;
    e.perr = (^w) ^ pbit;
    sbq.push_back(e);
    if (!hold) start = 1'b0;
    for (int i = 0; i < DW; i++) begin
      repeat (g[i]) begin
        data_en = 1'b0; serial_data = 1'bx; tick();
      end
      data_en = 1'b1; serial_data = bseq[i]; tick();
    end
    if (PAR) begin
      repeat (g[DW]) begin
        data_en = 1'b0; serial_data = 1'bx; tick();
      end
      data_en = 1'b1; serial_data = pbit; tick();
    end
    data_en = 1'b0; serial_data = 1'bx;
    tick();
    start = 1'b0;
    chk("busy_after_word", busy, 1'b0);
    chk("bit_cnt_idle", bit_cnt, '0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_en = 1'b0; serial_data = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_bit_cnt", bit_cnt, '0);
    #3 reset = 1'b0;

    // 1,0,1,0,0,1,0,1 continuous, then with three stalls carrying X data
    send(8'b1010_0101, '0, 0, 1'b0, 1'b0);
    chk("data_out_held", data_out, 8'hA5);
    send(8'b1010_0101, 9'b0_0010_0110, 0, 1'b0, 1'b0);

    // abort after 4 bits, abort wins over data_en on the same edge
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_en = 1'b1; serial_data = 1'b1; tick();
    end
    chk("bit_cnt_mid_word", bit_cnt, 4);
    abort = 1'b1; data_en = 1'b1; tick();
    abort = 1'b0; data_en = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_bit_cnt", bit_cnt, '0);
    chk("abort_data_out", data_out, 8'hA5);
    chk("abort_done", done, 1'b0);
    tick();

    // asynchronous reset in the middle of a word
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_en = 1'b1; serial_data = 1'b1; tick();
    end
    data_en = 1'b0;
    chk("busy_mid_word", busy, 1'b1);
    #4 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_data_out", data_out, '0);
    chk("async_rst_bit_cnt", bit_cnt, '0);
    #3 reset = 1'b0;
    send(8'b0011_1100, '0, 0, 1'b0, 1'b0);

    // start held high through the word and DONE: one word only
    send(DW'($urandom), '0, 0, 1'b1, 1'b0);
    tick();
    chk("no_reaccept_busy", busy, 1'b0);

`ifdef SHIFT_PARITY_CHK_EN
    send(8'b1010_0101, '0, 0, 1'b0, 1'b1);
    send(8'b1010_0101, '0, 0, 1'b0, 1'b0);
`endif

    repeat (16) send(DW'($urandom), '0, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (3) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
